// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state enum and constants for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    // Quotient reported for a zero divisor; instances slice the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_nr_step.sv
// rtl/div_nr_step.sv - one combinational non-restoring add/subtract step
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_p_low,
    input  logic             i_dividend_msb,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_prev_neg,
    output logic [WIDTH:0]   o_p,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_divisor_ext;

    // The old P sign bit is dropped by the shift; the result always lands in
    // [-divisor, divisor), so modulo 2^(WIDTH+1) arithmetic is exact.
    assign w_shifted     = {i_p_low, i_dividend_msb};
    assign w_divisor_ext = {1'b0, i_divisor};
    assign o_p           = i_prev_neg ? (w_shifted + w_divisor_ext)
                                      : (w_shifted - w_divisor_ext);
    assign o_q_bit       = ~o_p[WIDTH];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - parametrised sequential divider; signed path compiled only with DIV_SIGNED_EN
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_Q = DIV_ZERO_Q[WIDTH-1:0];

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_zero;
    logic             r_done;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_dvs_zero;
    logic             w_last;
    logic [WIDTH:0]   w_p_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_dvs_zero = (divisor == '0);
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));

    // A negative final P means the last trial subtraction overshot by one divisor.
    assign w_rem = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_dvs) : r_p[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_dvd_neg;
    logic r_quo_neg;

    assign w_dvd_neg = sign_mode & dividend[WIDTH-1];
    assign w_dvs_neg = sign_mode & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (-dividend) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (-divisor) : divisor;

    // Sign flags ride along with the magnitudes so FIX can restore the signs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dvd_neg <= 1'b0;
            r_quo_neg <= 1'b0;
        end else if (w_accept) begin
            r_dvd_neg <= w_dvd_neg;
            r_quo_neg <= w_dvd_neg ^ w_dvs_neg;
        end
    end

    assign w_q_fix = r_quo_neg ? (-r_dvd) : r_dvd;
    assign w_r_fix = r_dvd_neg ? (-w_rem) : w_rem;
`else
    logic w_unused_sign_mode;

    assign w_unused_sign_mode = sign_mode;
    assign w_dvd_mag          = dividend;
    assign w_dvs_mag          = divisor;
    assign w_q_fix            = r_dvd;
    assign w_r_fix            = w_rem;
`endif

    div_nr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_p_low        (r_p[WIDTH-1:0]),
        .i_dividend_msb (r_dvd[WIDTH-1]),
        .i_divisor      (r_dvs),
        .i_prev_neg     (r_p[WIDTH]),
        .o_p            (w_p_next),
        .o_q_bit        (w_q_bit)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: zero divisors skip straight to FIX
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = w_dvs_zero ? ST_FIX : ST_ITER;
            ST_ITER: if (w_last) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, one quotient bit per ITER cycle, result registration in FIX
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_p        <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_zero     <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // A zero divisor keeps the raw dividend: it is returned as r.
                        r_dvd   <= w_dvs_zero ? dividend : w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_p     <= '0;
                        r_count <= '0;
                        r_zero  <= w_dvs_zero;
                    end
                end
                ST_ITER: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom.
                    r_p     <= w_p_next;
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_count <= r_count + CNT_W'(1);
                end
                ST_FIX: begin
                    r_q        <= r_zero ? ZERO_Q : w_q_fix;
                    r_r        <= r_zero ? r_dvd : w_r_fix;
                    r_div_zero <= r_zero;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign q        = r_q;
    assign r        = r_r;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq at WIDTH=32 and WIDTH=8
module tb_div_seq;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        int          acc;
        int          lat;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic        start32, sign32, busy32, done32, dz32;
    logic [31:0] dvd32, dvs32, q32, r32;
    logic        start8, sign8, busy8, done8, dz8;
    logic [7:0]  dvd8, dvs8, q8, r8;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t e32;
    exp_t e8;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq #(.WIDTH(32)) u_dut32 (
        .clock     (clk),
        .reset     (rst),
        .start     (start32),
        .sign_mode (sign32),
        .dividend  (dvd32),
        .divisor   (dvs32),
        .q         (q32),
        .r         (r32),
        .busy      (busy32),
        .done      (done32),
        .div_zero  (dz32)
    );

    div_seq #(.WIDTH(8)) u_dut8 (
        .clock     (clk),
        .reset     (rst),
        .start     (start8),
        .sign_mode (sign8),
        .dividend  (dvd8),
        .divisor   (dvs8),
        .q         (q8),
        .r         (r8),
        .busy      (busy8),
        .done      (done8),
        .div_zero  (dz8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [63:0] aq,
                         input logic [63:0] ar, input logic adz, input int now);
        check($sformatf("%s#%0d q", tag, e.id), aq, e.q);
        check($sformatf("%s#%0d r", tag, e.id), ar, e.r);
        check($sformatf("%s#%0d div_zero", tag, e.id), 64'(adz), 64'(e.dz));
        check($sformatf("%s#%0d latency", tag, e.id), 64'(now - e.acc), 64'(e.lat));
    endtask

    // Monitor for the 32-bit instance
    always @(negedge clk) begin
        if (!rst && done32) begin
            if (sb32.size() == 0) begin
                check("w32 unexpected done", 64'(done32), 64'd0);
            end else begin
                e32 = sb32.pop_front();
                score("w32", e32, 64'(q32), 64'(r32), dz32, cyc);
            end
        end
    end

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                check("w8 unexpected done", 64'(done8), 64'd0);
            end else begin
                e8 = sb8.pop_front();
                score("w8", e8, 64'(q8), 64'(r8), dz8, cyc);
            end
        end
    end

    // Caller is at a negedge; start is accepted at the following posedge.
    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int lat, input int id);
        dvd32   = a;
        dvs32   = b;
        sign32  = sm;
        start32 = 1'b1;
        sb32.push_back('{q: 64'(eq), r: 64'(er), dz: edz, acc: cyc + 1, lat: lat, id: id});
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz,
                       input int lat, input int id);
        dvd8   = a;
        dvs8   = b;
        start8 = 1'b1;
        sb8.push_back('{q: 64'(eq), r: 64'(er), dz: edz, acc: cyc + 1, lat: lat, id: id});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (sb32.size() != 0 || sb8.size() != 0); i++) @(negedge clk);
        if (sb32.size() != 0 || sb8.size() != 0) begin
            check("drain timeout", 64'(sb32.size() + sb8.size()), 64'd0);
            sb32.delete();
            sb8.delete();
        end
    endtask

    initial begin
        int bad;
        start32 = 1'b0; sign32 = 1'b0; dvd32 = '0; dvs32 = '0;
        start8  = 1'b0; sign8  = 1'b0; dvd8  = '0; dvs8  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst q32", 64'(q32), 64'd0);
        check("rst r32", 64'(r32), 64'd0);
        check("rst busy32", 64'(busy32), 64'd0);
        check("rst done32", 64'(done32), 64'd0);
        check("rst dz32", 64'(dz32), 64'd0);
        check("rst q8", 64'(q8), 64'd0);
        check("rst busy8", 64'(busy8), 64'd0);
        check("rst done8", 64'(done8), 64'd0);

        // 100 / 7 with busy held for the whole operation
        @(negedge clk);
        go32(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1);
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            if (!busy32 || done32) bad++;
            @(negedge clk);
        end
        check("busy throughout 100/7", 64'(bad), 64'd0);
        check("busy low on done", 64'(busy32), 64'd0);
        drain();
        repeat (3) @(negedge clk);
        check("held q", 64'(q32), 64'd14);
        check("held r", 64'(r32), 64'd2);

        // zero divisor
        @(negedge clk);
        go32(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 2);
        check("zero busy", 64'(busy32), 64'd1);
        drain();
        @(negedge clk);
        go32(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 3);
        drain();

`ifdef DIV_SIGNED_EN
        @(negedge clk);
        go32(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 4);
        drain();
        @(negedge clk);
        go32(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 5);
        drain();
        @(negedge clk);
        go32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 6);
        drain();
`else
        @(negedge clk);
        go32(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 4);
        drain();
        @(negedge clk);
        go32(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 33, 5);
        drain();
        @(negedge clk);
        go32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 33, 6);
        drain();
`endif

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        go32(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, 7);
        repeat (4) @(negedge clk);
        dvd32 = 32'd9; dvs32 = 32'd3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        drain();

        // reset mid-operation aborts without done
        @(negedge clk);
        dvd32 = 32'd5000; dvs32 = 32'd3; sign32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(busy32), 64'd0);
        check("abort q", 64'(q32), 64'd0);
        check("abort r", 64'(r32), 64'd0);
        check("abort done", 64'(done32), 64'd0);
        repeat (40) @(negedge clk);
        go32(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 8);
        drain();

        // WIDTH=8: 255 / 16, then back-to-back start on its done cycle
        @(negedge clk);
        go8(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 9, 1);
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                bad = 0;
                break;
            end
            @(negedge clk);
        end
        check("w8 done seen", 64'(bad), 64'd0);
        go8(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 2);
        check("w8 b2b held q", 64'(q8), 64'd15);
        drain();
        @(negedge clk);
        go8(8'h80, 8'd0, 8'hFF, 8'h80, 1'b1, 1, 3);
        drain();

        check("final sb32 empty", 64'(sb32.size()), 64'd0);
        check("final sb8 empty", 64'(sb8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
